lookupflow_learn: RTL and testbench

- Parametrised successor of the fixed-table flow lookup. Receives a 96-bit tuple (dst MAC [95:48], src MAC [47:0]) and the one-hot ingress port, and returns a one-hot forwarding mask.
- Learning mode: keeps a DEPTH-entry MAC table, learns source addresses, ages entries out, and floods unknown or multicast destinations.
- Static mode: forwards to a host-supplied mask, the same as the previous generation.
- Sits between the per-port RX parser and the switch fabric arbiter.

---
 rtl/lookupflow_pkg.sv | 28 ++
 rtl/lookupflow_learn_if.sv | 29 ++
 rtl/lookupflow_fdb_entry.sv | 78 +++++++
 rtl/lookupflow_learn.sv | 262 ++++++++++++++++++++++++++
 tb/tb_lookupflow_learn.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lookupflow_pkg.sv
// Shared definitions for the learning flow lookup.
//   - FSM state encoding
//   - tuple slice positions and the MAC multicast bit
//   - flood-mask helper (every port except the ingress port)
package lookupflow_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_UPDATE = 2'd2,
      ST_ACK    = 2'd3
   } state_e;

   localparam int MACW          = 48;
   localparam int MAC_MCAST_BIT = 40;
   localparam int DST_MSB       = 95;
   localparam int DST_LSB       = 48;
   localparam int SRC_MSB       = 47;
   localparam int SRC_LSB       = 0;
   localparam int MAX_NPORT     = 32;

   // Caller truncates the result to its own port count, which leaves
   // {NPORT{1}} & ~in_port.
   function automatic logic [MAX_NPORT-1:0] flood_mask(input logic [MAX_NPORT-1:0] in_port);
      return ~in_port;
   endfunction

endpackage

// File: rtl/lookupflow_learn_if.sv
// Request/response bundle between the RX parser (master) and the lookup (slave).
//   req/tuple/in_port/cmd_mode/cmd_fwd_port : lookup request
//   age_tick/flush                          : table maintenance strobes
//   ack/fwd_port/hit/busy                   : result and status
interface lookupflow_learn_if #(
   parameter int NPORT = 4
);
   logic             req;
   logic [95:0]      tuple;
   logic [NPORT-1:0] in_port;
   logic             cmd_mode;
   logic [NPORT-1:0] cmd_fwd_port;
   logic             age_tick;
   logic             flush;
   logic             ack;
   logic [NPORT-1:0] fwd_port;
   logic             hit;
   logic             busy;

   modport master (
      output req, tuple, in_port, cmd_mode, cmd_fwd_port, age_tick, flush,
      input  ack, fwd_port, hit, busy
   );

   modport slave (
      input  req, tuple, in_port, cmd_mode, cmd_fwd_port, age_tick, flush,
      output ack, fwd_port, hit, busy
   );
endinterface

// File: rtl/lookupflow_fdb_entry.sv
// One MAC table entry: valid bit, MAC, port and age counter.
//   clr_i      : invalidate (flush)
//   wr_en_i    : load wr_mac_i/wr_port_i, set valid, age = AGE_MAX
//   age_tick_i : decrement age; entry drops out when age goes 1 -> 0
//   dst/src_match_o : valid entry equal to the presented dst/src MAC
module lookupflow_fdb_entry
   import lookupflow_pkg::*;
#(
   parameter int NPORT   = 4,
   parameter int AGEW    = 4,
   parameter int AGE_MAX = 15
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             age_tick_i,
   input  logic             wr_en_i,
   input  logic [MACW-1:0]  wr_mac_i,
   input  logic [NPORT-1:0] wr_port_i,
   input  logic [MACW-1:0]  dst_mac_i,
   input  logic [MACW-1:0]  src_mac_i,
   output logic             valid_o,
   output logic [NPORT-1:0] port_o,
   output logic             dst_match_o,
   output logic             src_match_o
);

   logic             valid_q, valid_d;
   logic [MACW-1:0]  mac_q,   mac_d;
   logic [NPORT-1:0] port_q,  port_d;
   logic [AGEW-1:0]  age_q,   age_d;

   // Next entry state: a write wins over the aging step in the same cycle.
   always_comb begin
      valid_d = valid_q;
      mac_d   = mac_q;
      port_d  = port_q;
      age_d   = age_q;
      if (clr_i) begin
         valid_d = 1'b0;
      end else if (wr_en_i) begin
         valid_d = 1'b1;
         mac_d   = wr_mac_i;
         port_d  = wr_port_i;
         age_d   = AGEW'(AGE_MAX);
      end else if (age_tick_i && valid_q && (age_q != {AGEW{1'b0}})) begin
         age_d = age_q - AGEW'(1);
         if (age_q == AGEW'(1)) begin
            valid_d = 1'b0;
         end else begin
            valid_d = valid_q;
         end
      end else begin
         age_d = age_q;
      end
   end

   // Entry storage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         mac_q   <= {MACW{1'b0}};
         port_q  <= {NPORT{1'b0}};
         age_q   <= {AGEW{1'b0}};
      end else begin
         valid_q <= valid_d;
         mac_q   <= mac_d;
         port_q  <= port_d;
         age_q   <= age_d;
      end
   end

   assign valid_o     = valid_q;
   assign port_o      = port_q;
   assign dst_match_o = valid_q && (mac_q == dst_mac_i);
   assign src_match_o = valid_q && (mac_q == src_mac_i);

endmodule

// File: rtl/lookupflow_learn.sv
// Learning MAC lookup: scans a DEPTH-entry table one entry per cycle, learns
// the source MAC, ages entries and returns a one-hot forwarding mask.
// Static mode forwards to the host-supplied mask with no table access.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   bus (slave)        : request, maintenance strobes, result/status
module lookupflow_learn
   import lookupflow_pkg::*;
#(
   parameter int NPORT   = 4,
   parameter int DEPTH   = 8,
   parameter int AGEW    = 4,
   parameter int AGE_MAX = 15
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   lookupflow_learn_if.slave  bus
);

   localparam int             IDXW     = $clog2(DEPTH);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

   state_e state_q, state_d;

   logic [MACW-1:0]  dst_q, dst_d, src_q, src_d;
   logic [NPORT-1:0] in_port_q, in_port_d;
   logic [IDXW-1:0]  idx_q, idx_d, rr_q, rr_d;
   logic             dst_found_q, dst_found_d, src_found_q, src_found_d;
   logic             free_found_q, free_found_d;
   logic [NPORT-1:0] dst_port_q, dst_port_d;
   logic [IDXW-1:0]  src_idx_q, src_idx_d, free_idx_q, free_idx_d;
   logic [NPORT-1:0] res_port_q, res_port_d;
   logic             res_hit_q, res_hit_d;
   logic             flush_pend_q, flush_pend_d;
   logic             ack_q, ack_d, hit_q, hit_d, busy_q, busy_d;
   logic [NPORT-1:0] fwd_q, fwd_d;

   logic             clr_s, learn_ok_s;
   logic [DEPTH-1:0] wr_en_s, valid_s, dst_match_s, src_match_s;
   logic [NPORT-1:0] port_s [DEPTH];
   logic [NPORT-1:0] flood_s;

   for (genvar g = 0; g < DEPTH; g++) begin : gen_entry
      lookupflow_fdb_entry #(.NPORT(NPORT), .AGEW(AGEW), .AGE_MAX(AGE_MAX)) u_entry (
         .clk_i       (sys_clk),
         .rst_ni      (sys_rst_n),
         .clr_i       (clr_s),
         .age_tick_i  (bus.age_tick),
         .wr_en_i     (wr_en_s[g]),
         .wr_mac_i    (src_q),
         .wr_port_i   (in_port_q),
         .dst_mac_i   (dst_q),
         .src_mac_i   (src_q),
         .valid_o     (valid_s[g]),
         .port_o      (port_s[g]),
         .dst_match_o (dst_match_s[g]),
         .src_match_o (src_match_s[g])
      );
   end

   assign flood_s    = NPORT'(flood_mask(MAX_NPORT'(in_port_q)));
   assign learn_ok_s = !src_q[MAC_MCAST_BIT] && (src_q != {MACW{1'b0}});

   // FSM state register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; a pending flush blocks capture for one IDLE cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (flush_pend_q || bus.flush) begin
               state_d = ST_IDLE;
            end else if (bus.req) begin
               state_d = bus.cmd_mode ? ST_SEARCH : ST_ACK;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEARCH: begin
            if (idx_q == LAST_IDX) begin
               state_d = ST_UPDATE;
            end else begin
               state_d = ST_SEARCH;
            end
         end
         ST_UPDATE: state_d = ST_ACK;
         ST_ACK:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: capture, scan bookkeeping, learning writes and result.
   always_comb begin
      dst_d        = dst_q;
      src_d        = src_q;
      in_port_d    = in_port_q;
      idx_d        = idx_q;
      rr_d         = rr_q;
      dst_found_d  = dst_found_q;
      src_found_d  = src_found_q;
      free_found_d = free_found_q;
      dst_port_d   = dst_port_q;
      src_idx_d    = src_idx_q;
      free_idx_d   = free_idx_q;
      res_port_d   = res_port_q;
      res_hit_d    = res_hit_q;
      clr_s        = 1'b0;
      wr_en_s      = {DEPTH{1'b0}};
      // A flush seen outside IDLE waits until the current transaction is done.
      if (state_q == ST_IDLE) begin
         flush_pend_d = 1'b0;
      end else if (bus.flush) begin
         flush_pend_d = 1'b1;
      end else begin
         flush_pend_d = flush_pend_q;
      end
      case (state_q)
         ST_IDLE: begin
            if (flush_pend_q || bus.flush) begin
               clr_s = 1'b1;
            end else if (bus.req && !bus.cmd_mode) begin
               res_port_d = bus.cmd_fwd_port;
               res_hit_d  = 1'b0;
            end else if (bus.req) begin
               dst_d        = bus.tuple[DST_MSB:DST_LSB];
               src_d        = bus.tuple[SRC_MSB:SRC_LSB];
               in_port_d    = bus.in_port;
               idx_d        = {IDXW{1'b0}};
               dst_found_d  = 1'b0;
               src_found_d  = 1'b0;
               free_found_d = 1'b0;
            end else begin
               clr_s = 1'b0;
            end
         end
         ST_SEARCH: begin
            if (!dst_found_q && dst_match_s[idx_q]) begin
               dst_found_d = 1'b1;
               dst_port_d  = port_s[idx_q];
            end else begin
               dst_found_d = dst_found_q;
            end
            if (!src_found_q && src_match_s[idx_q]) begin
               src_found_d = 1'b1;
               src_idx_d   = idx_q;
            end else begin
               src_found_d = src_found_q;
            end
            if (!free_found_q && !valid_s[idx_q]) begin
               free_found_d = 1'b1;
               free_idx_d   = idx_q;
            end else begin
               free_found_d = free_found_q;
            end
            if (idx_q == LAST_IDX) begin
               idx_d = {IDXW{1'b0}};
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         ST_UPDATE: begin
            // Source learning: refresh, else first free slot, else round-robin victim.
            if (!learn_ok_s) begin
               rr_d = rr_q;
            end else if (src_found_q) begin
               wr_en_s[src_idx_q] = 1'b1;
            end else if (free_found_q) begin
               wr_en_s[free_idx_q] = 1'b1;
            end else begin
               wr_en_s[rr_q] = 1'b1;
               if (rr_q == LAST_IDX) begin
                  rr_d = {IDXW{1'b0}};
               end else begin
                  rr_d = rr_q + IDXW'(1);
               end
            end
            // Forwarding: flood multicast/unknown, filter same-port, else unicast.
            if (dst_q[MAC_MCAST_BIT] || !dst_found_q) begin
               res_port_d = flood_s;
               res_hit_d  = 1'b0;
            end else if (dst_port_q == in_port_q) begin
               res_port_d = {NPORT{1'b0}};
               res_hit_d  = 1'b1;
            end else begin
               res_port_d = dst_port_q;
               res_hit_d  = 1'b1;
            end
         end
         ST_ACK: begin
            res_port_d = res_port_q;
         end
         default: begin
            res_port_d = res_port_q;
         end
      endcase
      // Result strobe follows the ACK state by one cycle; mask/hit held until the next one.
      ack_d  = (state_q == ST_ACK);
      busy_d = (state_d != ST_IDLE);
      if (state_q == ST_ACK) begin
         fwd_d = res_port_q;
         hit_d = res_hit_q;
      end else begin
         fwd_d = fwd_q;
         hit_d = hit_q;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dst_q        <= {MACW{1'b0}};
         src_q        <= {MACW{1'b0}};
         in_port_q    <= {NPORT{1'b0}};
         idx_q        <= {IDXW{1'b0}};
         rr_q         <= {IDXW{1'b0}};
         dst_found_q  <= 1'b0;
         src_found_q  <= 1'b0;
         free_found_q <= 1'b0;
         dst_port_q   <= {NPORT{1'b0}};
         src_idx_q    <= {IDXW{1'b0}};
         free_idx_q   <= {IDXW{1'b0}};
         res_port_q   <= {NPORT{1'b0}};
         res_hit_q    <= 1'b0;
         flush_pend_q <= 1'b0;
         ack_q        <= 1'b0;
         fwd_q        <= {NPORT{1'b0}};
         hit_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         dst_q        <= dst_d;
         src_q        <= src_d;
         in_port_q    <= in_port_d;
         idx_q        <= idx_d;
         rr_q         <= rr_d;
         dst_found_q  <= dst_found_d;
         src_found_q  <= src_found_d;
         free_found_q <= free_found_d;
         dst_port_q   <= dst_port_d;
         src_idx_q    <= src_idx_d;
         free_idx_q   <= free_idx_d;
         res_port_q   <= res_port_d;
         res_hit_q    <= res_hit_d;
         flush_pend_q <= flush_pend_d;
         ack_q        <= ack_d;
         fwd_q        <= fwd_d;
         hit_q        <= hit_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.ack      = ack_q;
   assign bus.fwd_port = fwd_q;
   assign bus.hit      = hit_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_lookupflow_learn.sv
// Directed bench for lookupflow_learn (NPORT=4, DEPTH=8, AGE_MAX=15).
module tb_lookupflow_learn;

   localparam logic [47:0] MAC_A  = 48'h001e4f498191;
   localparam logic [47:0] MAC_B  = 48'h0023df85302a;
   localparam logic [47:0] MAC_C  = 48'h00aabbccdd01;
   localparam logic [47:0] MAC_D  = 48'h000c29aa5501;
   localparam logic [47:0] MAC_Z  = 48'h00000000ff00;
   localparam logic [47:0] MAC_M  = 48'h01005e000001;
   localparam logic [47:0] MAC_BC = 48'hffffffffffff;
   localparam logic [47:0] MAC_0  = 48'h000000000000;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   lookupflow_learn_if #(.NPORT(4)) bus ();

   lookupflow_learn #(.NPORT(4), .DEPTH(8), .AGEW(4), .AGE_MAX(15)) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .bus       (bus)
   );

   typedef struct {
      logic        mode;
      logic [47:0] dst;
      logic [47:0] src;
      logic [3:0]  inp;
      logic [3:0]  cmdp;
      logic [3:0]  exp_fwd;
      logic        exp_hit;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] smac(input int k);
      return 48'h0000000000a0 + 48'(k);
   endfunction

   task automatic idle_inputs();
      bus.req          = 1'b0;
      bus.tuple        = 96'h0;
      bus.in_port      = 4'b0000;
      bus.cmd_mode     = 1'b0;
      bus.cmd_fwd_port = 4'b0000;
      bus.age_tick     = 1'b0;
      bus.flush        = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic ticks(input int k);
      repeat (k) begin
         @(negedge clk);
         bus.age_tick = 1'b1;
         @(negedge clk);
         bus.age_tick = 1'b0;
      end
   endtask

   // One lookup; age_tick/flush pulses are raised after edge n (counted from capture).
   task automatic lk(input string name, input logic mode, input logic [47:0] dst,
                     input logic [47:0] src, input logic [3:0] inp, input logic [3:0] cmdp,
                     input int tick_at, input int flush_at,
                     input logic [3:0] exp_fwd, input logic exp_hit);
      int   lat;
      logic got;
      logic [3:0] fwd;
      logic h;
      @(posedge clk);
      @(negedge clk);
      bus.req          = 1'b1;
      bus.cmd_mode     = mode;
      bus.tuple        = {dst, src};
      bus.in_port      = inp;
      bus.cmd_fwd_port = cmdp;
      @(posedge clk);
      #1;
      // Disturb the request fields after capture; the result must not change.
      bus.tuple        = ~{dst, src};
      bus.in_port      = ~inp;
      bus.cmd_mode     = ~mode;
      bus.cmd_fwd_port = ~cmdp;
      lat = 0;
      got = 1'b0;
      for (int n = 1; n <= 40 && !got; n++) begin
         @(posedge clk);
         #1;
         bus.age_tick = 1'b0;
         bus.flush    = 1'b0;
         if (bus.ack) begin
            got = 1'b1;
            lat = n;
         end else begin
            if (n == tick_at) bus.age_tick = 1'b1;
            if (n == flush_at) bus.flush = 1'b1;
         end
      end
      bus.req = 1'b0;
      fwd = bus.fwd_port;
      h   = bus.hit;
      check({name, "_lat"}, 32'(lat), mode ? 32'd10 : 32'd1);
      check({name, "_fwd"}, {28'h0, fwd}, {28'h0, exp_fwd});
      check({name, "_hit"}, {31'h0, h}, {31'h0, exp_hit});
      check({name, "_busy"}, {31'h0, bus.busy}, 32'd0);
      @(posedge clk);
      #1;
      check({name, "_ack1"}, {31'h0, bus.ack}, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack",  {31'h0, bus.ack},      32'd0);
      check("rst_fwd",  {28'h0, bus.fwd_port}, 32'd0);
      check("rst_hit",  {31'h0, bus.hit},      32'd0);
      check("rst_busy", {31'h0, bus.busy},     32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven sequence starting from an empty table.
      vecs[0]  = '{1'b0, MAC_Z,  MAC_B, 4'b1000, 4'b0101, 4'b0101, 1'b0};
      vecs[1]  = '{1'b1, MAC_B,  MAC_A, 4'b0010, 4'b0000, 4'b1101, 1'b0};
      vecs[2]  = '{1'b1, MAC_A,  MAC_B, 4'b0100, 4'b0000, 4'b0010, 1'b1};
      vecs[3]  = '{1'b1, MAC_BC, MAC_C, 4'b1000, 4'b0000, 4'b0111, 1'b0};
      vecs[4]  = '{1'b1, MAC_B,  MAC_0, 4'b0100, 4'b0000, 4'b0000, 1'b1};
      vecs[5]  = '{1'b1, MAC_0,  MAC_D, 4'b0001, 4'b0000, 4'b1110, 1'b0};
      vecs[6]  = '{1'b1, MAC_C,  MAC_M, 4'b0001, 4'b0000, 4'b1000, 1'b1};
      vecs[7]  = '{1'b1, MAC_M,  MAC_A, 4'b0010, 4'b0000, 4'b1101, 1'b0};
      vecs[8]  = '{1'b0, MAC_A,  MAC_D, 4'b0001, 4'b1010, 4'b1010, 1'b0};
      vecs[9]  = '{1'b1, MAC_D,  MAC_C, 4'b0100, 4'b0000, 4'b0001, 1'b1};
      vecs[10] = '{1'b1, MAC_C,  MAC_A, 4'b0001, 4'b0000, 4'b0100, 1'b1};
      for (int i = 0; i < 11; i++) begin
         lk($sformatf("vec%0d", i), vecs[i].mode, vecs[i].dst, vecs[i].src, vecs[i].inp,
            vecs[i].cmdp, -1, -1, vecs[i].exp_fwd, vecs[i].exp_hit);
      end

      // Fill all 8 entries, then replace round-robin from entry 0.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         lk($sformatf("fill%0d", k), 1'b1, MAC_Z, smac(k), 4'b0001, 4'b0000, -1, -1, 4'b1110, 1'b0);
      end
      lk("fill8",    1'b1, MAC_Z,   smac(8), 4'b0001, 4'b0000, -1, -1, 4'b1110, 1'b0);
      lk("old_s0",   1'b1, smac(0), MAC_0,   4'b0010, 4'b0000, -1, -1, 4'b1101, 1'b0);
      lk("keep_s1",  1'b1, smac(1), MAC_0,   4'b0010, 4'b0000, -1, -1, 4'b0001, 1'b1);
      lk("new_s8",   1'b1, smac(8), MAC_0,   4'b0010, 4'b0000, -1, -1, 4'b0001, 1'b1);
      lk("fill9",    1'b1, MAC_Z,   smac(9), 4'b0001, 4'b0000, -1, -1, 4'b1110, 1'b0);
      lk("old_s1",   1'b1, smac(1), MAC_0,   4'b0010, 4'b0000, -1, -1, 4'b1101, 1'b0);

      // Plain aging: 14 ticks keep the entry, the 15th removes it.
      do_reset();
      lk("age_learn", 1'b1, MAC_Z, MAC_A, 4'b0010, 4'b0000, -1, -1, 4'b1101, 1'b0);
      ticks(14);
      lk("age_14",    1'b1, MAC_A, MAC_0, 4'b0001, 4'b0000, -1, -1, 4'b0010, 1'b1);
      ticks(1);
      lk("age_15",    1'b1, MAC_A, MAC_0, 4'b0001, 4'b0000, -1, -1, 4'b1110, 1'b0);

      // Refresh at tick 14 restarts the age.
      do_reset();
      lk("ref_learn", 1'b1, MAC_Z, MAC_A, 4'b0010, 4'b0000, -1, -1, 4'b1101, 1'b0);
      ticks(14);
      lk("ref_do",    1'b1, MAC_Z, MAC_A, 4'b0010, 4'b0000, -1, -1, 4'b1101, 1'b0);
      ticks(14);
      lk("ref_live",  1'b1, MAC_A, MAC_0, 4'b0001, 4'b0000, -1, -1, 4'b0010, 1'b1);
      ticks(1);
      lk("ref_dead",  1'b1, MAC_A, MAC_0, 4'b0001, 4'b0000, -1, -1, 4'b1110, 1'b0);

      // age_tick in the UPDATE cycle of a refresh: the write wins, port moves.
      do_reset();
      lk("upd_learn", 1'b1, MAC_Z, MAC_A, 4'b0010, 4'b0000, -1, -1, 4'b1101, 1'b0);
      ticks(14);
      lk("upd_tick",  1'b1, MAC_Z, MAC_A, 4'b0100, 4'b0000, 8, -1, 4'b1011, 1'b0);
      ticks(14);
      lk("upd_live",  1'b1, MAC_A, MAC_0, 4'b0001, 4'b0000, -1, -1, 4'b0100, 1'b1);
      ticks(1);
      lk("upd_dead",  1'b1, MAC_A, MAC_0, 4'b0001, 4'b0000, -1, -1, 4'b1110, 1'b0);

      // Flush mid-SEARCH: current lookup sees the old table, the next one misses.
      do_reset();
      lk("fl_learn", 1'b1, MAC_Z, MAC_A, 4'b0010, 4'b0000, -1, -1, 4'b1101, 1'b0);
      lk("fl_mid",   1'b1, MAC_A, MAC_0, 4'b0001, 4'b0000, -1, 3, 4'b0010, 1'b1);
      lk("fl_after", 1'b1, MAC_A, MAC_0, 4'b0001, 4'b0000, -1, -1, 4'b1110, 1'b0);

      // Async reset mid-SEARCH.
      do_reset();
      lk("ar_learn", 1'b1, MAC_Z, MAC_A, 4'b0010, 4'b0000, -1, -1, 4'b1101, 1'b0);
      @(posedge clk);
      @(negedge clk);
      bus.req      = 1'b1;
      bus.cmd_mode = 1'b1;
      bus.tuple    = {MAC_A, MAC_0};
      bus.in_port  = 4'b0001;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("ar_busy_before", {31'h0, bus.busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_ack",  {31'h0, bus.ack},      32'd0);
      check("ar_fwd",  {28'h0, bus.fwd_port}, 32'd0);
      check("ar_hit",  {31'h0, bus.hit},      32'd0);
      check("ar_busy", {31'h0, bus.busy},     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      lk("ar_empty", 1'b1, MAC_A, MAC_0, 4'b0001, 4'b0000, -1, -1, 4'b1110, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
